// File: rtl/fpu_cvt_unit.sv
// Multi-cycle int <-> single-precision float converter (FCVT.S.W/S.WU/W.S/WU.S).
// One op in flight at a time: IDLE -> NORM -> RND -> DONE, all five RISC-V rounding modes.
module fpu_cvt_unit #(
    parameter int INT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       cvt_op,
    input  logic [2:0]       flt_rm,
    input  logic [INT_W-1:0] opa,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] fpu_res,
    output logic [4:0]       fflags,
    output logic             fpu_busy
);

    localparam int W = INT_W + 32;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_NORM = 2'd1;
    localparam logic [1:0] S_RND  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [7:0] BIG_E  = 8'(127 + INT_W);
    localparam logic [INT_W-1:0] SMAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] SMIN = {1'b1, {(INT_W-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [2:0]       rm_q, rm_d;
    logic [INT_W-1:0] opa_q, opa_d;
    logic             sign_q, sign_d;
    logic [7:0]       exp_q, exp_d;
    logic [W-1:0]     fld_q, fld_d;
    logic             zero_q, zero_d;
    logic             nan_q, nan_d;
    logic             big_q, big_d;
    logic [INT_W-1:0] res_q, res_d;
    logic [4:0]       flags_q, flags_d;

    logic             int_sign;
    logic [INT_W-1:0] int_mag;
    logic [6:0]       msb;
    logic [7:0]       f_exp, be, sh;
    logic [22:0]      f_man;
    logic [23:0]      m24;
    logic             g, r, s, lsb, inexact, up, nv;
    logic [22:0]      mant;
    logic [23:0]      mant_c;
    logic [7:0]       exp_r;
    logic [INT_W:0]   mag_r;
    logic [INT_W-1:0] neg_r;

    always_comb begin
        int_sign = !op_q[0] && opa_q[INT_W-1];
        int_mag  = int_sign ? -opa_q : opa_q;
        msb      = '0;
        for (int i = 0; i < INT_W; i++) begin
            if (int_mag[i]) msb = 7'(i);
        end
        f_exp = opa_q[30:23];
        f_man = opa_q[22:0];
        be    = (f_exp == 8'd0) ? 8'd1 : f_exp;
        m24   = {f_exp != 8'd0, f_man};
        // binary point of the guard field sits between bits 32 and 31
        sh    = be - 8'd118;

        mant = fld_q[W-2 -: 23];
        if (!op_q[1]) begin
            g   = fld_q[W-25];
            r   = fld_q[W-26];
            s   = |fld_q[W-27:0];
            lsb = mant[0];
        end else begin
            g   = fld_q[31];
            r   = fld_q[30];
            s   = |fld_q[29:0];
            lsb = fld_q[32];
        end
        inexact = g | r | s;
        case (rm_q)
            3'b001:  up = 1'b0;
            3'b010:  up = inexact && sign_q;
            3'b011:  up = inexact && !sign_q;
            3'b100:  up = g;
            default: up = g && (r || s || lsb);
        endcase
        mant_c = {1'b0, mant} + {23'd0, up};
        exp_r  = exp_q + {7'd0, mant_c[23]};
        mag_r  = {1'b0, fld_q[W-1:32]} + {{INT_W{1'b0}}, up};
        neg_r  = -mag_r[INT_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rm_d    = rm_q;
        opa_d   = opa_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        fld_d   = fld_q;
        zero_d  = zero_q;
        nan_d   = nan_q;
        big_d   = big_q;
        res_d   = res_q;
        flags_d = flags_q;
        nv      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d    = cvt_op;
                    rm_d    = flt_rm;
                    opa_d   = opa;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (!op_q[1]) begin
                    sign_d = int_sign;
                    exp_d  = 8'd127 + {1'b0, msb};
                    fld_d  = {int_mag, 32'd0} << (7'(INT_W-1) - msb);
                    zero_d = (int_mag == '0);
                    nan_d  = 1'b0;
                    big_d  = 1'b0;
                end else begin
                    sign_d = opa_q[31];
                    zero_d = 1'b0;
                    nan_d  = (f_exp == 8'hFF) && (f_man != 23'd0);
                    big_d  = (be >= BIG_E);
                    // below 2^-8 only stickiness survives
                    fld_d  = (be < 8'd118) ? {{(W-1){1'b0}}, |m24}
                                           : ({{(W-24){1'b0}}, m24} << sh);
                end
                state_d = flush ? S_IDLE : S_RND;
            end
            S_RND: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    res_d   = '1;
                    if (!op_q[1]) begin
                        res_d[31:0] = zero_q ? 32'd0 : {sign_q, exp_r, mant_c[22:0]};
                    end else if (!op_q[0]) begin
                        nv = 1'b1;
                        if (nan_q)             res_d = SMAX;
                        else if (big_q)        res_d = sign_q ? SMIN : SMAX;
                        else if (!sign_q) begin
                            if (mag_r > {1'b0, SMAX}) res_d = SMAX;
                            else begin res_d = mag_r[INT_W-1:0]; nv = 1'b0; end
                        end else begin
                            if (mag_r > {1'b0, SMIN}) res_d = SMIN;
                            else begin res_d = neg_r; nv = 1'b0; end
                        end
                    end else begin
                        nv = 1'b1;
                        if (nan_q)             res_d = '1;
                        else if (big_q)        res_d = sign_q ? '0 : '1;
                        else if (!sign_q) begin
                            if (mag_r[INT_W]) res_d = '1;
                            else begin res_d = mag_r[INT_W-1:0]; nv = 1'b0; end
                        end else begin
                            res_d = '0;
                            nv    = (mag_r != '0);
                        end
                    end
                    flags_d = {nv, 3'b000, inexact && !nv};
                end
            end
            default: begin
                if (flush || out_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rm_q    <= '0;
            opa_q   <= '0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            fld_q   <= '0;
            zero_q  <= 1'b0;
            nan_q   <= 1'b0;
            big_q   <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rm_q    <= rm_d;
            opa_q   <= opa_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            fld_q   <= fld_d;
            zero_q  <= zero_d;
            nan_q   <= nan_d;
            big_q   <= big_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign fpu_busy  = (state_q != S_IDLE);
    assign fpu_res   = res_q;
    assign fflags    = flags_q;

endmodule
